uarc_irq_ctrl: RTL

Parametrised UARC receive-side interrupt and wait controller for the next-generation core. It arbitrates incoming `send` requests from up to `TOTAL_BUSES` UARC buses, offers the winner to the core as either an interrupt (vector plus data) or a `WAIT` completion, and performs the send-ack handshake. It also tracks handler activity. It replaces the single-cycle priority-encoder path inside the core with a registered, handshaked, configurable unit.

---
 rtl/uarc_irq_ctrl.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uarc_irq_ctrl.sv
// ---------------------------------------------------------------------------
// uarc_irq_ctrl
//
// Receive-side interrupt / WAIT controller for the UARC buses.
//
// The block picks one bus whose send request is qualified by a per-bus mask.
// The enable mask applies to interrupts; the selection mask applies while the
// core sits in WAIT. It offers the winner to the core, and on accept it
// captures the bus data and pulses that bus's send-ack for one cycle. It also
// tracks whether an interrupt handler is running, so interrupts never nest.
// WAIT completions are still served while a handler runs.
//
// Optional feature macro: UARC_IRQ_ROUND_ROBIN_EN
//   defined   : round-robin arbitration starting at the bus after the last
//               accepted one
//   undefined : fixed priority, lowest bus index wins
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   receiver_sends      per-bus send request (held until acked)
//   receiver_datas      per-bus data, bus i at [i*WORD_WIDTH +: WORD_WIDTH]
//   receiver_send_acks  one-cycle ack pulse, at most one bit high
//   cfg_we/sel/bus/value  mask / vector configuration write port
//   wait_req            core is executing WAIT
//   irq_valid           offer pending
//   irq_is_wait         offer completes a WAIT rather than jumping to a vector
//   irq_bus             offered bus
//   irq_address         vector of the offered bus (zero when nothing offered)
//   irq_accept          core takes the offer
//   irq_data            data captured at the last accept
//   irq_return          core executed the interrupt return
//   interrupt_active    handler in progress
// ---------------------------------------------------------------------------
module uarc_irq_ctrl #(
   parameter int WORD_WIDTH         = 32,
   parameter int TOTAL_BUSES        = 4,
   parameter int PROGRAM_ADDR_WIDTH = 16,
   localparam int BUS_IDX_WIDTH     = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [TOTAL_BUSES-1:0]            receiver_sends,
   input  logic [TOTAL_BUSES*WORD_WIDTH-1:0] receiver_datas,
   output logic [TOTAL_BUSES-1:0]            receiver_send_acks,
   input  logic                              cfg_we,
   input  logic [1:0]                        cfg_sel,
   input  logic [BUS_IDX_WIDTH-1:0]          cfg_bus,
   input  logic [WORD_WIDTH-1:0]             cfg_value,
   input  logic                              wait_req,
   output logic                              irq_valid,
   output logic                              irq_is_wait,
   output logic [BUS_IDX_WIDTH-1:0]          irq_bus,
   output logic [PROGRAM_ADDR_WIDTH-1:0]     irq_address,
   input  logic                              irq_accept,
   output logic [WORD_WIDTH-1:0]             irq_data,
   input  logic                              irq_return,
   output logic                              interrupt_active
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OFFER  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [BUS_IDX_WIDTH:0]   NUM_BUSES = TOTAL_BUSES[BUS_IDX_WIDTH:0];
   localparam logic [BUS_IDX_WIDTH-1:0] LAST_BUS  = BUS_IDX_WIDTH'(TOTAL_BUSES - 1);

   // configuration state
   logic [TOTAL_BUSES-1:0]        enables_r;
   logic [TOTAL_BUSES-1:0]        selections_r;
   logic [PROGRAM_ADDR_WIDTH-1:0] vectors_r [TOTAL_BUSES];

   // control state and registered outputs
   state_t                        state_r;
   logic [BUS_IDX_WIDTH-1:0]      irq_bus_r;
   logic                          irq_is_wait_r;
   logic                          resume_active_r;
   logic [TOTAL_BUSES-1:0]        ack_r;
   logic [WORD_WIDTH-1:0]         irq_data_r;
   logic                          valid_r;
   logic                          active_r;
`ifdef UARC_IRQ_ROUND_ROBIN_EN
   logic [BUS_IDX_WIDTH-1:0]      rr_r;
   logic [BUS_IDX_WIDTH-1:0]      rr_nxt_s;
`endif

   // combinational helpers
   logic                          cfg_in_range_s;
   logic [TOTAL_BUSES-1:0]        cand_s;
   logic                          win_found_s;
   logic [BUS_IDX_WIDTH-1:0]      win_bus_s;
   logic                          offered_mask_s;
   logic                          cancel_s;
   logic [WORD_WIDTH-1:0]         offered_data_s;
   logic                          unused_cfg_s;

   state_t                        state_nxt_s;
   logic [BUS_IDX_WIDTH-1:0]      bus_nxt_s;
   logic                          wait_nxt_s;
   logic                          resume_nxt_s;
   logic [TOTAL_BUSES-1:0]        ack_nxt_s;
   logic [WORD_WIDTH-1:0]         data_nxt_s;

   assign cfg_in_range_s = ({1'b0, cfg_bus} < NUM_BUSES) && (cfg_sel != 2'd3);
   assign unused_cfg_s   = ^cfg_value;

   // A bus whose ack is pulsing this cycle still holds its send (the sender has
   // not seen the ack yet), so it is excluded to avoid serving it twice.
   // While a handler runs, only WAIT completions may be offered.
   assign cand_s = ((state_r != ST_ACTIVE) || wait_req)
                 ? (receiver_sends & (wait_req ? selections_r : enables_r) & ~ack_r)
                 : {TOTAL_BUSES{1'b0}};

   assign offered_mask_s = irq_is_wait_r ? selections_r[irq_bus_r] : enables_r[irq_bus_r];
   assign cancel_s       = !receiver_sends[irq_bus_r] || !offered_mask_s;
   assign offered_data_s = receiver_datas[irq_bus_r*WORD_WIDTH +: WORD_WIDTH];

   // Winner search: first candidate starting at the arbitration origin.
   always_comb begin
      int j;
      logic [BUS_IDX_WIDTH-1:0] idx;
      win_found_s = 1'b0;
      win_bus_s   = {BUS_IDX_WIDTH{1'b0}};
      j           = 0;
      idx         = {BUS_IDX_WIDTH{1'b0}};
      for (int k = 0; k < TOTAL_BUSES; k++) begin
`ifdef UARC_IRQ_ROUND_ROBIN_EN
         j = int'(rr_r) + k;
         j = (j >= TOTAL_BUSES) ? (j - TOTAL_BUSES) : j;
`else
         j = k;
`endif
         idx         = BUS_IDX_WIDTH'(j);
         win_bus_s   = (!win_found_s && cand_s[idx]) ? idx : win_bus_s;
         win_found_s = win_found_s | cand_s[idx];
      end
   end

   // Next-state and next-output logic of the offer FSM.
   always_comb begin
      state_nxt_s  = state_r;
      bus_nxt_s    = irq_bus_r;
      wait_nxt_s   = irq_is_wait_r;
      resume_nxt_s = resume_active_r;
      ack_nxt_s    = {TOTAL_BUSES{1'b0}};
      data_nxt_s   = irq_data_r;
`ifdef UARC_IRQ_ROUND_ROBIN_EN
      rr_nxt_s     = rr_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (win_found_s) begin
               state_nxt_s  = ST_OFFER;
               bus_nxt_s    = win_bus_s;
               wait_nxt_s   = wait_req;
               resume_nxt_s = 1'b0;
            end else begin
               state_nxt_s  = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            // Return takes precedence; pending requests are arbitrated next cycle.
            if (irq_return) begin
               state_nxt_s  = ST_IDLE;
            end else if (win_found_s) begin
               state_nxt_s  = ST_OFFER;
               bus_nxt_s    = win_bus_s;
               wait_nxt_s   = wait_req;
               resume_nxt_s = 1'b1;
            end else begin
               state_nxt_s  = ST_ACTIVE;
            end
         end
         ST_OFFER: begin
            // Accept wins over a same-cycle cancel.
            if (irq_accept) begin
               ack_nxt_s   = TOTAL_BUSES'(1'b1) << irq_bus_r;
               data_nxt_s  = offered_data_s;
               state_nxt_s = (!irq_is_wait_r || resume_active_r) ? ST_ACTIVE : ST_IDLE;
`ifdef UARC_IRQ_ROUND_ROBIN_EN
               rr_nxt_s    = (irq_bus_r == LAST_BUS) ? {BUS_IDX_WIDTH{1'b0}}
                                                     : irq_bus_r + BUS_IDX_WIDTH'(1);
`endif
            end else if (cancel_s) begin
               state_nxt_s = resume_active_r ? ST_ACTIVE : ST_IDLE;
            end else begin
               state_nxt_s = ST_OFFER;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         irq_bus_r       <= {BUS_IDX_WIDTH{1'b0}};
         irq_is_wait_r   <= 1'b0;
         resume_active_r <= 1'b0;
         ack_r           <= {TOTAL_BUSES{1'b0}};
         irq_data_r      <= {WORD_WIDTH{1'b0}};
         valid_r         <= 1'b0;
         active_r        <= 1'b0;
`ifdef UARC_IRQ_ROUND_ROBIN_EN
         rr_r            <= {BUS_IDX_WIDTH{1'b0}};
`endif
      end else begin
         state_r         <= state_nxt_s;
         irq_bus_r       <= bus_nxt_s;
         irq_is_wait_r   <= wait_nxt_s;
         resume_active_r <= resume_nxt_s;
         ack_r           <= ack_nxt_s;
         irq_data_r      <= data_nxt_s;
         valid_r         <= (state_nxt_s == ST_OFFER);
         active_r        <= (state_nxt_s == ST_ACTIVE);
`ifdef UARC_IRQ_ROUND_ROBIN_EN
         rr_r            <= rr_nxt_s;
`endif
      end
   end

   // Configuration writes; arbitration above sees the pre-write values.
   always_ff @(posedge clk) begin
      if (reset) begin
         enables_r    <= {TOTAL_BUSES{1'b0}};
         selections_r <= {TOTAL_BUSES{1'b0}};
         for (int i = 0; i < TOTAL_BUSES; i++) begin
            vectors_r[i] <= {PROGRAM_ADDR_WIDTH{1'b0}};
         end
      end else if (cfg_we && cfg_in_range_s) begin
         case (cfg_sel)
            2'd0:    enables_r[cfg_bus]    <= cfg_value[0];
            2'd1:    selections_r[cfg_bus] <= cfg_value[0];
            2'd2:    vectors_r[cfg_bus]    <= cfg_value[PROGRAM_ADDR_WIDTH-1:0];
            default: begin
            end
         endcase
      end
   end

   assign receiver_send_acks = ack_r;
   assign irq_valid          = valid_r;
   assign irq_is_wait        = irq_is_wait_r;
   assign irq_bus            = irq_bus_r;
   assign irq_address        = valid_r ? vectors_r[irq_bus_r] : {PROGRAM_ADDR_WIDTH{1'b0}};
   assign irq_data           = irq_data_r;
   assign interrupt_active   = active_r;

endmodule
